// File: rtl/rc4_keystream_decrypt.sv
`default_nettype none
// =============================================================================
// Module   : rc4_keystream_decrypt
// Brief    : RC4 PRGA stage. Swaps the pre-shuffled S-box in place, XORs the
//            keystream with ROM ciphertext and writes plaintext to RAM.
// Revision : 1.0
// =============================================================================
module rc4_keystream_decrypt #(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic              finish_o,
  output logic              s_mem_sel_o,
  output logic [7:0]        s_addr_o,
  output logic [7:0]        s_data_o,
  output logic              s_wen_o,
  input  logic [7:0]        s_q_i,
  output logic [MSG_AW-1:0] rom_addr_o,
  input  logic [7:0]        rom_q_i,
  output logic [MSG_AW-1:0] ram_addr_o,
  output logic [7:0]        ram_data_o,
  output logic              ram_wen_o
);

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_INC_I   = 4'd1;
  localparam logic [3:0] ST_WAIT_SI = 4'd2;
  localparam logic [3:0] ST_GET_SI  = 4'd3;
  localparam logic [3:0] ST_SET_J   = 4'd4;
  localparam logic [3:0] ST_WAIT_SJ = 4'd5;
  localparam logic [3:0] ST_GET_SJ  = 4'd6;
  localparam logic [3:0] ST_WR_I    = 4'd7;
  localparam logic [3:0] ST_WR_J    = 4'd8;
  localparam logic [3:0] ST_RD_F    = 4'd9;
  localparam logic [3:0] ST_WAIT_F  = 4'd10;
  localparam logic [3:0] ST_GET_F   = 4'd11;
  localparam logic [3:0] ST_WR_OUT  = 4'd12;
  localparam logic [3:0] ST_NEXT    = 4'd13;
  localparam logic [3:0] ST_DONE    = 4'd14;

  localparam logic [MSG_AW-1:0] C_K_LAST = MSG_AW'(MSG_LEN - 1);
  localparam logic [MSG_AW-1:0] C_K_ONE  = MSG_AW'(1);

  logic [3:0]        state_q, state_d;
  logic [7:0]        i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, f_q, f_d;
  logic [MSG_AW-1:0] k_q, k_d;
  logic              finish_q, finish_d, sel_q, sel_d;
  logic [7:0]        s_addr_q, s_addr_d, s_data_q, s_data_d;
  logic              s_wen_q, s_wen_d;
  logic [MSG_AW-1:0] rom_addr_q, rom_addr_d, ram_addr_q, ram_addr_d;
  logic [7:0]        ram_data_q, ram_data_d;
  logic              ram_wen_q, ram_wen_d;

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    si_d       = si_q;
    sj_d       = sj_q;
    f_d        = f_q;
    k_d        = k_q;
    finish_d   = finish_q;
    sel_d      = sel_q;
    s_addr_d   = s_addr_q;
    s_data_d   = s_data_q;
    s_wen_d    = s_wen_q;
    rom_addr_d = rom_addr_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_wen_d  = ram_wen_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          i_d      = 8'd0;
          j_d      = 8'd0;
          k_d      = '0;
          finish_d = 1'b0;
          sel_d    = 1'b1;
          state_d  = ST_INC_I;
        end
      end
      ST_INC_I: begin
        i_d      = i_q + 8'd1;
        s_addr_d = i_q + 8'd1;
        state_d  = ST_WAIT_SI;
      end
      ST_WAIT_SI: state_d = ST_GET_SI;
      ST_GET_SI: begin
        si_d    = s_q_i;
        j_d     = j_q + s_q_i;
        state_d = ST_SET_J;
      end
      ST_SET_J: begin
        s_addr_d = j_q;
        state_d  = ST_WAIT_SJ;
      end
      ST_WAIT_SJ: state_d = ST_GET_SJ;
      ST_GET_SJ: begin
        sj_d    = s_q_i;
        state_d = ST_WR_I;
      end
      // When i==j the second write lands on the same address and leaves si there.
      ST_WR_I: begin
        s_addr_d = i_q;
        s_data_d = sj_q;
        s_wen_d  = 1'b1;
        state_d  = ST_WR_J;
      end
      ST_WR_J: begin
        s_addr_d = j_q;
        s_data_d = si_q;
        s_wen_d  = 1'b1;
        state_d  = ST_RD_F;
      end
      ST_RD_F: begin
        s_wen_d    = 1'b0;
        s_addr_d   = si_q + sj_q;
        rom_addr_d = k_q;
        state_d    = ST_WAIT_F;
      end
      ST_WAIT_F: state_d = ST_GET_F;
      ST_GET_F: begin
        f_d     = s_q_i;
        state_d = ST_WR_OUT;
      end
      ST_WR_OUT: begin
        ram_addr_d = k_q;
        ram_data_d = f_q ^ rom_q_i;
        ram_wen_d  = 1'b1;
        state_d    = ST_NEXT;
      end
      ST_NEXT: begin
        ram_wen_d = 1'b0;
        if (k_q == C_K_LAST) begin
          finish_d = 1'b1;
          sel_d    = 1'b0;
          state_d  = ST_DONE;
        end else begin
          k_d     = k_q + C_K_ONE;
          state_d = ST_INC_I;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      i_q        <= 8'd0;
      j_q        <= 8'd0;
      si_q       <= 8'd0;
      sj_q       <= 8'd0;
      f_q        <= 8'd0;
      k_q        <= '0;
      finish_q   <= 1'b0;
      sel_q      <= 1'b0;
      s_addr_q   <= 8'd0;
      s_data_q   <= 8'd0;
      s_wen_q    <= 1'b0;
      rom_addr_q <= '0;
      ram_addr_q <= '0;
      ram_data_q <= 8'd0;
      ram_wen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      f_q        <= f_d;
      k_q        <= k_d;
      finish_q   <= finish_d;
      sel_q      <= sel_d;
      s_addr_q   <= s_addr_d;
      s_data_q   <= s_data_d;
      s_wen_q    <= s_wen_d;
      rom_addr_q <= rom_addr_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_wen_q  <= ram_wen_d;
    end
  end

  assign finish_o    = finish_q;
  assign s_mem_sel_o = sel_q;
  assign s_addr_o    = s_addr_q;
  assign s_data_o    = s_data_q;
  assign s_wen_o     = s_wen_q;
  assign rom_addr_o  = rom_addr_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_data_o  = ram_data_q;
  assign ram_wen_o   = ram_wen_q;

endmodule
`default_nettype wire

// File: tb/tb_rc4_keystream_decrypt.sv
`default_nettype none
// Testbench for rc4_keystream_decrypt: four instances (4, 9, 32, 300 bytes) with
// behavioural S/ROM/RAM memories, checked against an array-based RC4 PRGA model.
module tb_rc4_keystream_decrypt;
  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start [NI];
  logic load [NI];
  logic finish_w [NI];
  logic sel_w [NI];
  logic s_wen_w [NI];
  logic ram_wen_w [NI];
  logic [7:0] s_addr_w [NI];
  logic [7:0] s_data_w [NI];
  logic [7:0] ram_data_w [NI];
  logic [7:0] s_q_r [NI];
  logic [7:0] rom_q_r [NI];
  logic [8:0] rom_addr_w [NI];
  logic [8:0] ram_addr_w [NI];

  logic [7:0] s_init [NI][256];
  logic [7:0] s_mem [NI][256];
  logic [7:0] rom [NI][512];
  logic [7:0] ram [NI][512];

  logic [7:0] exp_ram [512];
  logic [7:0] exp_s [256];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L  = (g == 0) ? 4 : (g == 1) ? 9 : (g == 2) ? 32 : 300;
    localparam int AW = (g == 3) ? 9 : 5;
    logic [AW-1:0] rom_a, ram_a;
    rc4_keystream_decrypt #(.MSG_LEN(L), .MSG_AW(AW)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start[g]),
      .finish_o    (finish_w[g]),
      .s_mem_sel_o (sel_w[g]),
      .s_addr_o    (s_addr_w[g]),
      .s_data_o    (s_data_w[g]),
      .s_wen_o     (s_wen_w[g]),
      .s_q_i       (s_q_r[g]),
      .rom_addr_o  (rom_a),
      .rom_q_i     (rom_q_r[g]),
      .ram_addr_o  (ram_a),
      .ram_data_o  (ram_data_w[g]),
      .ram_wen_o   (ram_wen_w[g])
    );
    assign rom_addr_w[g] = 9'(rom_a);
    assign ram_addr_w[g] = 9'(ram_a);
  end

  // Synchronous single-cycle-read memories; S writes only land while the DUT owns the port.
  always @(posedge clk) begin
    for (int n = 0; n < NI; n++) begin
      if (load[n]) begin
        for (int a = 0; a < 256; a++) s_mem[n][a] <= s_init[n][a];
        for (int a = 0; a < 512; a++) ram[n][a] <= 8'h00;
      end else begin
        if (s_wen_w[n] && sel_w[n]) s_mem[n][s_addr_w[n]] <= s_data_w[n];
        if (ram_wen_w[n]) ram[n][ram_addr_w[n]] <= ram_data_w[n];
      end
      s_q_r[n]   <= s_mem[n][s_addr_w[n]];
      rom_q_r[n] <= rom[n][rom_addr_w[n]];
    end
  end

  function automatic int len_of(input int n);
    return (n == 0) ? 4 : (n == 1) ? 9 : (n == 2) ? 32 : 300;
  endfunction

  task automatic set_identity(input int n);
    for (int a = 0; a < 256; a++) s_init[n][a] = 8'(a);
  endtask

  task automatic set_random_perm(input int n);
    int b;
    logic [7:0] t;
    set_identity(n);
    for (int a = 255; a > 0; a--) begin
      b = $urandom_range(a, 0);
      t = s_init[n][a]; s_init[n][a] = s_init[n][b]; s_init[n][b] = t;
    end
  endtask

  task automatic set_ksa_key(input int n);
    logic [7:0] key [3];
    logic [7:0] t;
    int j;
    key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
    set_identity(n);
    j = 0;
    for (int a = 0; a < 256; a++) begin
      j = (j + s_init[n][a] + key[a % 3]) % 256;
      t = s_init[n][a]; s_init[n][a] = s_init[n][j]; s_init[n][j] = t;
    end
  endtask

  task automatic fill_rom(input int n, input int mode);
    for (int a = 0; a < 512; a++)
      rom[n][a] = (mode == 0) ? 8'h00 : (mode == 1) ? 8'hFF : 8'($urandom);
  endtask

  task automatic load_s(input int n);
    @(negedge clk); load[n] = 1'b1;
    @(negedge clk); load[n] = 1'b0;
  endtask

  // Reference RC4 PRGA over the bench's current copy of S for instance n.
  task automatic model_prga(input int n);
    int mi, mj;
    logic [7:0] t;
    for (int a = 0; a < 256; a++) exp_s[a] = s_mem[n][a];
    mi = 0; mj = 0;
    for (int k = 0; k < len_of(n); k++) begin
      mi = (mi + 1) % 256;
      mj = (mj + exp_s[mi]) % 256;
      t = exp_s[mi]; exp_s[mi] = exp_s[mj]; exp_s[mj] = t;
      exp_ram[k] = exp_s[(exp_s[mi] + exp_s[mj]) % 256] ^ rom[n][k];
    end
  endtask

  task automatic run(input int n, input int busy_at, input int rst_at,
                     output int edges, output int conflicts, output int s_wen_cyc,
                     output int ram_wen_cyc, output logic fin0, output logic sel0);
    int limit;
    limit = 13 * len_of(n) + 40;
    edges = 0; conflicts = 0; s_wen_cyc = 0; ram_wen_cyc = 0;
    @(negedge clk); start[n] = 1'b1;
    @(posedge clk); #1; start[n] = 1'b0;
    fin0 = finish_w[n];
    sel0 = sel_w[n];
    while (edges < limit) begin
      @(posedge clk); #1;
      edges++;
      start[n] = 1'b0;
      if (s_wen_w[n] && ram_wen_w[n]) conflicts++;
      if (s_wen_w[n]) s_wen_cyc++;
      if (ram_wen_w[n]) ram_wen_cyc++;
      if (edges == busy_at) start[n] = 1'b1;
      if (edges == rst_at) begin
        rst_n = 1'b0;
        break;
      end
      if (finish_w[n]) break;
    end
  endtask

  function automatic logic [45:0] outs(input int n);
    return {finish_w[n], sel_w[n], s_wen_w[n], ram_wen_w[n], s_addr_w[n], s_data_w[n],
            rom_addr_w[n], ram_addr_w[n], ram_data_w[n]};
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int n = 0; n < NI; n++) begin
      n_checks++;
      if (outs(n) !== 46'd0) begin
        n_fail++; $display("FAIL reset_outs[%0d]: got %h expected 0", n, outs(n));
      end
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_identity_zero();
    int e, c, sw, rw, bad;
    logic f0, s0;
    logic [7:0] ref_c [4];
    ref_c[0] = 8'h02; ref_c[1] = 8'h05; ref_c[2] = 8'h07; ref_c[3] = 8'h0D;
    set_identity(0); fill_rom(0, 0); load_s(0); model_prga(0);
    run(0, -1, -1, e, c, sw, rw, f0, s0);
    n_checks++; if (e !== 52) begin n_fail++; $display("FAIL t1_edges: got %0d expected 52", e); end
    n_checks++; if (f0 !== 1'b0 || s0 !== 1'b1) begin n_fail++; $display("FAIL t1_start_flags: got fin=%b sel=%b expected 0 1", f0, s0); end
    n_checks++; if (c !== 0) begin n_fail++; $display("FAIL t1_wen_overlap: got %0d expected 0", c); end
    n_checks++; if (sw !== 8 || rw !== 4) begin n_fail++; $display("FAIL t1_wen_cycles: got s=%0d ram=%0d expected 8 4", sw, rw); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (ram[0][k] !== ref_c[k] || ram[0][k] !== exp_ram[k]) begin
        n_fail++; $display("FAIL t1_ram[%0d]: got %h expected %h", k, ram[0][k], ref_c[k]);
      end
    end
    repeat (3) @(negedge clk);
    n_checks++; if (finish_w[0] !== 1'b1 || sel_w[0] !== 1'b0) begin n_fail++; $display("FAIL t1_done_flags: got fin=%b sel=%b expected 1 0", finish_w[0], sel_w[0]); end
    bad = 0;
    for (int a = 0; a < 256; a++) if (s_mem[0][a] !== exp_s[a]) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL t1_final_s: got %0d wrong entries expected 0", bad); end
  endtask

  task automatic test_identity_ff();
    int e, c, sw, rw;
    logic f0, s0;
    logic [7:0] ref_c [4];
    ref_c[0] = 8'hFD; ref_c[1] = 8'hFA; ref_c[2] = 8'hF8; ref_c[3] = 8'hF2;
    set_identity(0); fill_rom(0, 1); load_s(0);
    run(0, -1, -1, e, c, sw, rw, f0, s0);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (ram[0][k] !== ref_c[k]) begin
        n_fail++; $display("FAIL t2_ram[%0d]: got %h expected %h", k, ram[0][k], ref_c[k]);
      end
    end
    n_checks++;
    if ({s_mem[0][2], s_mem[0][3], s_mem[0][5], s_mem[0][4], s_mem[0][9]} !== 40'h03_05_02_09_04) begin
      n_fail++; $display("FAIL t2_final_s: got %h %h %h %h %h expected 03 05 02 09 04",
                         s_mem[0][2], s_mem[0][3], s_mem[0][5], s_mem[0][4], s_mem[0][9]);
    end
  endtask

  task automatic test_key_vector();
    int e, c, sw, rw;
    logic f0, s0;
    logic [71:0] ct, pt;
    ct = 72'hBB_F3_16_E8_D9_40_AF_0A_D3;
    pt = 72'h50_6C_61_69_6E_74_65_78_74;
    set_ksa_key(1); fill_rom(1, 2);
    for (int k = 0; k < 9; k++) rom[1][k] = ct[71-8*k -: 8];
    load_s(1); model_prga(1);
    run(1, -1, -1, e, c, sw, rw, f0, s0);
    n_checks++; if (e !== 117) begin n_fail++; $display("FAIL t3_edges: got %0d expected 117", e); end
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if (ram[1][k] !== pt[71-8*k -: 8] || ram[1][k] !== exp_ram[k]) begin
        n_fail++; $display("FAIL t3_ram[%0d]: got %h expected %h", k, ram[1][k], pt[71-8*k -: 8]);
      end
    end
  endtask

  task automatic test_reset_midbyte();
    int e, c, sw, rw;
    logic f0, s0;
    set_identity(0); fill_rom(0, 0); load_s(0);
    run(0, -1, 19, e, c, sw, rw, f0, s0);
    repeat (2) @(negedge clk);
    n_checks++; if (outs(0) !== 46'd0) begin n_fail++; $display("FAIL t4_outs_in_reset: got %h expected 0", outs(0)); end
    n_checks++; if (ram[0][0] !== 8'h02 || ram[0][1] !== 8'h00) begin n_fail++; $display("FAIL t4_partial: got %h %h expected 02 00", ram[0][0], ram[0][1]); end
    rst_n = 1'b1;
    set_identity(0); load_s(0);
    run(0, -1, -1, e, c, sw, rw, f0, s0);
    n_checks++; if (e !== 52) begin n_fail++; $display("FAIL t4_edges: got %0d expected 52", e); end
    n_checks++;
    if ({ram[0][0], ram[0][1], ram[0][2], ram[0][3]} !== 32'h02_05_07_0D) begin
      n_fail++; $display("FAIL t4_ram: got %h %h %h %h expected 02 05 07 0d", ram[0][0], ram[0][1], ram[0][2], ram[0][3]);
    end
  endtask

  task automatic test_busy_start();
    int e, c, sw, rw;
    logic f0, s0;
    set_identity(0); fill_rom(0, 0); load_s(0);
    run(0, 10, -1, e, c, sw, rw, f0, s0);
    n_checks++; if (e !== 52) begin n_fail++; $display("FAIL t5_busy_edges: got %0d expected 52", e); end
    n_checks++;
    if ({ram[0][0], ram[0][1], ram[0][2], ram[0][3]} !== 32'h02_05_07_0D) begin
      n_fail++; $display("FAIL t5_busy_ram: got %h %h %h %h expected 02 05 07 0d", ram[0][0], ram[0][1], ram[0][2], ram[0][3]);
    end
    fill_rom(0, 2); model_prga(0);
    run(0, -1, -1, e, c, sw, rw, f0, s0);
    n_checks++; if (f0 !== 1'b0 || s0 !== 1'b1) begin n_fail++; $display("FAIL t5_restart_flags: got fin=%b sel=%b expected 0 1", f0, s0); end
    n_checks++; if (e !== 52) begin n_fail++; $display("FAIL t5_restart_edges: got %0d expected 52", e); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (ram[0][k] !== exp_ram[k]) begin
        n_fail++; $display("FAIL t5_restart_ram[%0d]: got %h expected %h", k, ram[0][k], exp_ram[k]);
      end
    end
  endtask

  task automatic test_random(input int n, input int perm);
    int e, c, sw, rw, bad;
    logic f0, s0;
    if (perm != 0) set_random_perm(n); else set_identity(n);
    fill_rom(n, 2); load_s(n); model_prga(n);
    run(n, -1, -1, e, c, sw, rw, f0, s0);
    n_checks++; if (e !== 13 * len_of(n)) begin n_fail++; $display("FAIL rnd%0d_edges: got %0d expected %0d", n, e, 13 * len_of(n)); end
    n_checks++; if (c !== 0 || sw !== 2 * len_of(n) || rw !== len_of(n)) begin
      n_fail++; $display("FAIL rnd%0d_wen: got ovl=%0d s=%0d ram=%0d expected 0 %0d %0d", n, c, sw, rw, 2 * len_of(n), len_of(n));
    end
    bad = 0;
    for (int k = 0; k < len_of(n); k++) if (ram[n][k] !== exp_ram[k]) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rnd%0d_ram: got %0d wrong bytes expected 0", n, bad); end
    bad = 0;
    for (int a = 0; a < 256; a++) if (s_mem[n][a] !== exp_s[a]) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rnd%0d_final_s: got %0d wrong entries expected 0", n, bad); end
  endtask

  initial begin
    for (int n = 0; n < NI; n++) begin
      start[n] = 1'b0;
      load[n]  = 1'b0;
    end
    test_reset();
    test_identity_zero();
    test_identity_ff();
    test_key_vector();
    test_reset_midbyte();
    test_busy_start();
    test_random(0, 1);
    test_random(1, 1);
    test_random(2, 0);
    test_random(2, 1);
    test_random(3, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
